// File: rtl/trace_checker_pkg.sv
// Shared constants and types for the commit-trace checker.
// A golden record is pc, instr, then r0..r31.
package trace_checker_pkg;

    localparam int REC_LEN = 34;
    localparam int LAST_K  = REC_LEN - 1;

    localparam logic [5:0] FIELD_PC   = 6'd0;
    localparam logic [5:0] FIELD_IR   = 6'd1;
    localparam logic [5:0] FIELD_REG0 = 6'd2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

endpackage

// File: rtl/trace_checker_if.sv
// CPU/regfile/golden-ROM/status bundle between the checker and its environment.
// The master side is the environment; the slave side is the checker.
interface trace_checker_if #(
    parameter int GOLD_AW = 16,
    parameter int CNT_W   = 16
) ();
    logic               instr_change;
    logic [31:0]        cpu_pc;
    logic [31:0]        cpu_ir;
    logic [4:0]         dbg_raddr;
    logic [31:0]        dbg_rdata;
    logic [GOLD_AW-1:0] gold_addr;
    logic               gold_rd;
    logic [31:0]        gold_data;
    logic               cpu_stall;
    logic               busy;
    logic               done;
    logic               mismatch;
    logic               overrun;
    logic [CNT_W-1:0]   err_count;
    logic [CNT_W-1:0]   err_index;
    logic [5:0]         err_field;
    logic [CNT_W-1:0]   checked_count;

    modport master (
        output instr_change, cpu_pc, cpu_ir, dbg_rdata, gold_data,
        input  dbg_raddr, gold_addr, gold_rd, cpu_stall, busy, done, mismatch,
               overrun, err_count, err_index, err_field, checked_count
    );

    modport slave (
        input  instr_change, cpu_pc, cpu_ir, dbg_rdata, gold_data,
        output dbg_raddr, gold_addr, gold_rd, cpu_stall, busy, done, mismatch,
               overrun, err_count, err_index, err_field, checked_count
    );
endinterface

// File: rtl/trace_edge_detect.sv
// Registers the CPU retire toggle and emits a one-cycle pulse on its rising edge.
module trace_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic evt_o
);
    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= 1'b0;
        else        sig_q <= sig_i;
    end

    assign evt_o = sig_i & ~sig_q;
endmodule

// File: rtl/trace_checker.sv
// Compares each retired instruction's PC, IR and register file against a golden
// trace ROM, one word per cycle, stalling the CPU and latching the first mismatch.
module trace_checker
    import trace_checker_pkg::*;
#(
    parameter int GOLD_AW   = 16,
    parameter int NUM_INSTR = 1024,
    parameter int CNT_W     = 16
) (
    input  logic            clk_in,
    input  logic            reset,
    trace_checker_if.slave  tif
);
    localparam logic [CNT_W-1:0] NUM_C = CNT_W'(NUM_INSTR);

    state_e             state_q, state_d;
    logic [5:0]         k_q, k_d;
    logic [GOLD_AW-1:0] base_q, base_d, addr_q, addr_d;
    logic [31:0]        pc_q, pc_d, ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, ec_q, ec_d, eidx_q, eidx_d;
    logic [5:0]         efld_q, efld_d;
    logic               mm_q, mm_d, ov_q, ov_d;
    logic               evt, rd, fail, in_run;
    logic [31:0]        actual;
    logic [4:0]         ridx;

    trace_edge_detect u_edge (
        .clk   (clk_in),
        .rst_n (reset),
        .sig_i (tif.instr_change),
        .evt_o (evt)
    );

    assign in_run = (state_q == RUN);
    assign ridx   = 5'(k_q - FIELD_REG0);

    always_comb begin
        actual = tif.dbg_rdata;
        if (k_q == FIELD_PC)      actual = pc_q;
        else if (k_q == FIELD_IR) actual = ir_q;
    end

    assign fail = in_run && (tif.gold_data != actual);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        ec_d    = ec_q;
        eidx_d  = eidx_q;
        efld_d  = efld_q;
        mm_d    = mm_q;
        ov_d    = ov_q;
        rd      = 1'b0;
        case (state_q)
            IDLE: if (evt) begin
                pc_d    = tif.cpu_pc;
                ir_d    = tif.cpu_ir;
                addr_d  = base_q;
                rd      = 1'b1;
                k_d     = 6'd0;
                state_d = RUN;
            end
            RUN: begin
                if (evt) ov_d = 1'b1;
                if (fail) begin
                    if (~&ec_q) ec_d = ec_q + CNT_W'(1);
                    if (!mm_q) begin
                        mm_d   = 1'b1;
                        eidx_d = cnt_q;
                        efld_d = k_q;
                    end
                end
                // Prefetch the next word so gold_data lines up with k next cycle.
                if (k_q != 6'(LAST_K)) begin
                    k_d    = k_q + 6'd1;
                    addr_d = base_q + GOLD_AW'(k_q) + GOLD_AW'(1);
                    rd     = 1'b1;
                end else begin
                    k_d     = 6'd0;
                    base_d  = base_q + GOLD_AW'(REC_LEN);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = (cnt_q + CNT_W'(1) == NUM_C) ? DONE : IDLE;
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            ec_q    <= '0;
            eidx_q  <= '0;
            efld_q  <= '0;
            mm_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            ec_q    <= ec_d;
            eidx_q  <= eidx_d;
            efld_q  <= efld_d;
            mm_q    <= mm_d;
            ov_q    <= ov_d;
        end
    end

    // addr_d equals addr_q whenever no read is issued, so the address holds.
    assign tif.gold_addr     = addr_d;
    assign tif.gold_rd       = rd;
    assign tif.dbg_raddr     = (in_run && k_q >= FIELD_REG0) ? ridx : 5'd0;
    assign tif.busy          = in_run;
    assign tif.cpu_stall     = in_run | ((state_q == IDLE) & evt);
    assign tif.done          = (state_q == DONE);
    assign tif.mismatch      = mm_q;
    assign tif.overrun       = ov_q;
    assign tif.err_count     = ec_q;
    assign tif.err_index     = eidx_q;
    assign tif.err_field     = efld_q;
    assign tif.checked_count = cnt_q;
endmodule

// File: tb/tb_trace_checker.sv
// Directed bench: stimulus pushes expected per-record results, a monitor checks
// them when busy falls; a second instance with NUM_INSTR=2 covers done.
module tb_trace_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    trace_checker_if #(.GOLD_AW(16), .CNT_W(16)) ta ();
    trace_checker_if #(.GOLD_AW(16), .CNT_W(16)) tbi ();

    trace_checker #(.GOLD_AW(16), .NUM_INSTR(8), .CNT_W(16)) dut_a (
        .clk_in (clk), .reset (rst_n), .tif (ta));
    trace_checker #(.GOLD_AW(16), .NUM_INSTR(2), .CNT_W(16)) dut_b (
        .clk_in (clk), .reset (rst_n), .tif (tbi));

    logic [31:0] gmem [0:511];
    logic [31:0] rf   [0:31];

    assign ta.dbg_rdata  = rf[ta.dbg_raddr];
    assign tbi.dbg_rdata = rf[tbi.dbg_raddr];
    always @(posedge clk) if (ta.gold_rd)  ta.gold_data  <= gmem[ta.gold_addr[8:0]];
    always @(posedge clk) if (tbi.gold_rd) tbi.gold_data <= gmem[tbi.gold_addr[8:0]];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] base, checked, ec, idx;
        logic [5:0]  fld;
        logic        mm, ov;
    } exp_t;
    exp_t q[$];
    exp_t e;

    task automatic push(input int base, input int checked, input int ec, input int idx,
                        input int fld, input bit mm, input bit ov);
        exp_t x;
        x.base = 16'(base); x.checked = 16'(checked); x.ec = 16'(ec);
        x.idx = 16'(idx); x.fld = 6'(fld); x.mm = mm; x.ov = ov;
        q.push_back(x);
    endtask

    // Monitor for dut_a: a record is presented when busy falls.
    int          bcyc;
    logic        bprev;
    logic [15:0] first;
    always @(negedge clk) begin
        if (!rst_n) begin
            bcyc  = 0;
            bprev = 1'b0;
        end else begin
            if (ta.gold_rd && !ta.busy) first = ta.gold_addr;
            if (ta.busy) bcyc++;
            else if (bprev) begin
                if (q.size() == 0) chk("unexpected_record", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("busy_cycles", 64'(bcyc), 34);
                    chk("first_addr", first, e.base);
                    chk("checked_count", ta.checked_count, e.checked);
                    chk("err_count", ta.err_count, e.ec);
                    chk("mismatch", ta.mismatch, e.mm);
                    chk("err_index", ta.err_index, e.idx);
                    chk("err_field", ta.err_field, e.fld);
                    chk("overrun", ta.overrun, e.ov);
                    chk("stall_low", ta.cpu_stall, 0);
                end
                bcyc = 0;
            end
            bprev = ta.busy;
        end
    end

    task automatic init_gold();
        for (int i = 0; i < 512; i++) gmem[i] = 32'h0;
        for (int r = 0; r < 8; r++) begin
            gmem[34*r]   = 32'h0040_0000 + 32'(4*r);
            gmem[34*r+1] = 32'h3c01_0000;
        end
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    endtask

    task automatic retire(input int r);
        ta.cpu_pc = 32'h0040_0000 + 32'(4*r);
        ta.cpu_ir = 32'h3c01_0000;
        @(posedge clk); #1 ta.instr_change = 1'b1;
        @(posedge clk); #1 ta.instr_change = 1'b0;
    endtask

    task automatic wait_rec();
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        init_gold();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic retire_b(input int r, input bit chk_ignored);
        tbi.cpu_pc = 32'h0040_0000 + 32'(4*r);
        tbi.cpu_ir = 32'h3c01_0000;
        @(posedge clk); #1 tbi.instr_change = 1'b1;
        @(negedge clk);
        if (chk_ignored) begin
            chk("b_ignored_stall", tbi.cpu_stall, 0);
            chk("b_ignored_rd", tbi.gold_rd, 0);
        end
        @(posedge clk); #1 tbi.instr_change = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        ta.instr_change = 1'b0;  tbi.instr_change = 1'b0;
        ta.cpu_pc = '0; ta.cpu_ir = '0; tbi.cpu_pc = '0; tbi.cpu_ir = '0;
        init_gold();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {ta.busy, ta.cpu_stall, ta.done, ta.mismatch, ta.overrun,
                            ta.gold_rd, ta.dbg_raddr, ta.err_field}, 0);
        chk("reset_counts", {ta.gold_addr, ta.err_count, ta.err_index, ta.checked_count}, 0);
        rst_n = 1'b1;

        // Matching records; second one must start at base 34.
        push(0, 1, 0, 0, 0, 0, 0);  retire(0); wait_rec();
        push(34, 2, 0, 0, 0, 0, 0); retire(1); wait_rec();

        // r5 mismatch in record 0 (field 2+5=7), then a clean record.
        do_reset();
        gmem[7] = 32'h0000_0010;
        rf[5]   = 32'h0000_0011;
        push(0, 1, 1, 0, 7, 1, 0);  retire(0); wait_rec();
        rf[5] = 32'h0;
        push(34, 2, 1, 0, 7, 1, 0); retire(1); wait_rec();

        // PC mismatch on record 2, r10 mismatch on record 3: first error kept.
        do_reset();
        gmem[68]  = 32'hdead_beef;
        gmem[114] = 32'h0000_0005;
        push(0, 1, 0, 0, 0, 0, 0);   retire(0); wait_rec();
        push(34, 2, 0, 0, 0, 0, 0);  retire(1); wait_rec();
        push(68, 3, 1, 2, 0, 1, 0);  retire(2); wait_rec();
        push(102, 4, 2, 2, 0, 1, 0); retire(3); wait_rec();

        // Retire edge injected at RUN k=10.
        do_reset();
        push(0, 1, 0, 0, 0, 0, 1);
        retire(0);
        repeat (10) @(posedge clk);
        #1 ta.instr_change = 1'b1;
        @(posedge clk); #1 ta.instr_change = 1'b0;
        wait_rec();

        // Reset low at RUN k=20 aborts the record; next record reads from 0.
        retire(1);
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_reset_flags", {ta.busy, ta.cpu_stall, ta.done, ta.mismatch, ta.overrun,
                                   ta.gold_rd, ta.dbg_raddr, ta.err_field}, 0);
        chk("midrun_reset_counts", {ta.gold_addr, ta.err_count, ta.err_index,
                                    ta.checked_count}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push(0, 1, 0, 0, 0, 0, 0); retire(0); wait_rec();

        // NUM_INSTR=2 instance: done after second record, third edge ignored.
        do_reset();
        retire_b(0, 1'b0); wait_rec();
        chk("b_done_after_1", tbi.done, 0);
        chk("b_count_1", tbi.checked_count, 1);
        retire_b(1, 1'b0); wait_rec();
        chk("b_done_after_2", tbi.done, 1);
        chk("b_count_2", tbi.checked_count, 2);
        retire_b(2, 1'b1); wait_rec();
        chk("b_done_sticky", tbi.done, 1);
        chk("b_count_final", tbi.checked_count, 2);
        chk("b_stall_final", {tbi.cpu_stall, tbi.busy}, 0);
        chk("b_mismatch", tbi.mismatch, 0);

        chk("scoreboard_drained", 64'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
